// File: rtl/exp6_unidade_controle_pkg.sv
// Shared state encoding for the exp6 memory-game control unit.
// Codes are visible on db_estado and reused by the top-level state display.
package exp6_unidade_controle_pkg;

  typedef enum logic [3:0] {
    StInicial      = 4'h0,
    StPrepara      = 4'h1,
    StIniciaRodada = 4'h2,
    StMostra       = 4'h3,
    StApaga        = 4'h4,
    StEspera       = 4'h5,
    StRegistra     = 4'h6,
    StCompara      = 4'h7,
    StProxima      = 4'h8,
    StFimRodada    = 4'h9,
    StProxRodada   = 4'hA,
    StFimAcerto    = 4'hB,
    StFimErro      = 4'hC,
    StFimTimeout   = 4'hD
  } estado_e;

endpackage

// File: rtl/exp6_unidade_controle_contador_m.sv
// Modulo-M counter used to time how long the round's new element stays lit.
// Holds at the terminal count instead of wrapping; the FSM leaves MOSTRA there anyway.
module exp6_unidade_controle_contador_m #(
  parameter int unsigned M = 500
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] Last = W'(M - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera_s) begin
      cnt_d = '0;
    end else if (conta && (cnt_q != Last)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim = (cnt_q == Last);

endmodule

// File: rtl/exp6_unidade_controle.sv
// Moore FSM sequencing the exp6 memory-game datapath: show element, collect plays, judge.
// All outputs decode from the state register only.
module exp6_unidade_controle
  import exp6_unidade_controle_pkg::*;
#(
  parameter int unsigned LED_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       enderecoIgualRodada,
  input  logic       fimL,
  input  logic       timeout,
  output logic       zeraCR,
  output logic       zeraE,
  output logic       contaCR,
  output logic       contaE,
  output logic       limpaRC,
  output logic       registraRC,
  output logic       zeraLeds,
  output logic       registraLeds,
  output logic       led_selector,
  output logic       contaT,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       deu_timeout,
  output logic [3:0] db_estado
);

  estado_e state_q, state_d;
  logic    fim_mostra;

  exp6_unidade_controle_contador_m #(
    .M (LED_CYCLES)
  ) contador_m (
    .clock  (clock),
    .reset  (reset),
    .zera_s (state_q == StIniciaRodada),
    .conta  (state_q == StMostra),
    .fim    (fim_mostra)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StInicial;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInicial:      if (iniciar) state_d = StPrepara;
      StPrepara:      state_d = StIniciaRodada;
      StIniciaRodada: state_d = StMostra;
      StMostra:       if (fim_mostra) state_d = StApaga;
      StApaga:        state_d = StEspera;
      // A play pulse wins over a simultaneous timeout.
      StEspera: begin
        if (jogada_feita)  state_d = StRegistra;
        else if (timeout)  state_d = StFimTimeout;
      end
      StRegistra:     state_d = StCompara;
      StCompara: begin
        if (!jogada_correta)          state_d = StFimErro;
        else if (enderecoIgualRodada) state_d = StFimRodada;
        else                          state_d = StProxima;
      end
      StProxima:      state_d = StEspera;
      StFimRodada:    state_d = fimL ? StFimAcerto : StProxRodada;
      StProxRodada:   state_d = StIniciaRodada;
      StFimAcerto, StFimErro, StFimTimeout: if (iniciar) state_d = StPrepara;
      default:        state_d = StInicial;
    endcase
  end

  always_comb begin
    zeraCR       = 1'b0;
    zeraE        = 1'b0;
    contaCR      = 1'b0;
    contaE       = 1'b0;
    limpaRC      = 1'b0;
    registraRC   = 1'b0;
    zeraLeds     = 1'b0;
    registraLeds = 1'b0;
    led_selector = 1'b0;
    contaT       = 1'b0;
    pronto       = 1'b0;
    acertou      = 1'b0;
    errou        = 1'b0;
    deu_timeout  = 1'b0;
    case (state_q)
      StPrepara: begin
        zeraCR   = 1'b1;
        zeraE    = 1'b1;
        limpaRC  = 1'b1;
        zeraLeds = 1'b1;
      end
      StIniciaRodada: begin
        zeraE        = 1'b1;
        limpaRC      = 1'b1;
        registraLeds = 1'b1;
        led_selector = 1'b1;
      end
      StApaga:      zeraLeds   = 1'b1;
      StEspera:     contaT     = 1'b1;
      StRegistra:   registraRC = 1'b1;
      StProxima:    contaE     = 1'b1;
      StProxRodada: contaCR    = 1'b1;
      StFimAcerto: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      StFimErro: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      StFimTimeout: begin
        pronto      = 1'b1;
        errou       = 1'b1;
        deu_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Directed bench for the exp6 control FSM with a short display time (LED_CYCLES=4).
module tb_exp6_unidade_controle;

  logic clock = 1'b0;
  logic reset, iniciar, jogada_feita, jogada_correta, enderecoIgualRodada, fimL, timeout;
  logic zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds, registraLeds;
  logic led_selector, contaT, pronto, acertou, errou, deu_timeout;
  logic [3:0] db_estado;

  localparam logic [13:0] OZcr = 14'h2000, OZe = 14'h1000, OCcr = 14'h0800, OCe = 14'h0400;
  localparam logic [13:0] OLrc = 14'h0200, ORrc = 14'h0100, OZl = 14'h0080, ORl = 14'h0040;
  localparam logic [13:0] OLs  = 14'h0020, OCt  = 14'h0010, OPr = 14'h0008, OAc = 14'h0004;
  localparam logic [13:0] OEr  = 14'h0002, OTo  = 14'h0001;

  int n_checks = 0;
  int n_fail   = 0;
  int cr_count = 0;

  exp6_unidade_controle #(
    .LED_CYCLES (4)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .jogada_feita        (jogada_feita),
    .jogada_correta      (jogada_correta),
    .enderecoIgualRodada (enderecoIgualRodada),
    .fimL                (fimL),
    .timeout             (timeout),
    .zeraCR              (zeraCR),
    .zeraE               (zeraE),
    .contaCR             (contaCR),
    .contaE              (contaE),
    .limpaRC             (limpaRC),
    .registraRC          (registraRC),
    .zeraLeds            (zeraLeds),
    .registraLeds        (registraLeds),
    .led_selector        (led_selector),
    .contaT              (contaT),
    .pronto              (pronto),
    .acertou             (acertou),
    .errou               (errou),
    .deu_timeout         (deu_timeout),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (contaCR) cr_count++;

  wire [13:0] outs = {zeraCR, zeraE, contaCR, contaE, limpaRC, registraRC, zeraLeds,
                      registraLeds, led_selector, contaT, pronto, acertou, errou, deu_timeout};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] st, input string tag);
    int n = 0;
    while (db_estado !== st && n < 40) begin
      step();
      n++;
    end
    check(tag, db_estado, st);
  endtask

  // Plays one round of 'plays' correct plays starting from INICIA_RODADA/ESPERA.
  task automatic run_round(input int plays, input bit last);
    for (int i = 0; i < plays; i++) begin
      wait_state(4'h5, "espera");
      jogada_feita = 1'b1;
      jogada_correta = 1'b1;
      enderecoIgualRodada = (i == plays - 1);
      step();
      jogada_feita = 1'b0;
      check("registra_outs", outs, ORrc);
      step();
      check("compara", db_estado, 4'h7);
      step();
      if (i < plays - 1) begin
        check("proxima", db_estado, 4'h8);
        check("proxima_outs", outs, OCe);
        step();
      end else begin
        check("fim_rodada", db_estado, 4'h9);
        fimL = last;
        step();
        fimL = 1'b0;
        if (last) begin
          check("fim_acerto", db_estado, 4'hB);
        end else begin
          check("prox_rodada", db_estado, 4'hA);
          check("prox_rodada_outs", outs, OCcr);
          step();
          check("reinicia_rodada", db_estado, 4'h2);
        end
      end
    end
  endtask

  initial begin
    int n;
    int cr_base;
    reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; jogada_correta = 1'b0;
    enderecoIgualRodada = 1'b0; fimL = 1'b0; timeout = 1'b0;
    step(); step();
    check("reset_state", db_estado, 4'h0);
    check("reset_outs", outs, 14'h0);
    reset = 1'b1;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("prepara", db_estado, 4'h1);
    check("prepara_outs", outs, OZcr | OZe | OLrc | OZl);
    step();
    check("inicia_rodada_outs", outs, OZe | OLrc | ORl | OLs);
    wait_state(4'h5, "espera_first");
    check("espera_outs", outs, OCt);

    // Reset mid-ESPERA
    reset = 1'b0;
    step(); step();
    check("midreset_state", db_estado, 4'h0);
    check("midreset_outs", outs, 14'h0);
    reset = 1'b1;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("restart1", db_estado, 4'h1);
    step();
    check("restart2", db_estado, 4'h2);
    check("restart2_leds", {registraLeds, led_selector}, 2'b11);
    step();
    check("restart3", db_estado, 4'h3);

    // MOSTRA lasts 4 clocks; a play pulse here must be ignored
    n = 0;
    while (db_estado === 4'h3 && n < 20) begin
      jogada_feita = (n == 1);
      step();
      n++;
    end
    jogada_feita = 1'b0;
    check("mostra_cycles", n, 4);
    check("apaga", db_estado, 4'h4);
    check("apaga_outs", outs, OZl);
    step();
    check("espera_after_apaga", db_estado, 4'h5);
    step();
    check("espera_holds", db_estado, 4'h5);

    // Rounds 0..2
    run_round(1, 1'b0);
    run_round(2, 1'b0);
    run_round(3, 1'b0);

    // Wrong play
    wait_state(4'h5, "espera_erro");
    jogada_feita = 1'b1;
    jogada_correta = 1'b0;
    step();
    jogada_feita = 1'b0;
    step(); step();
    check("fim_erro", db_estado, 4'hC);
    check("fim_erro_outs", outs, OPr | OEr);
    step();
    check("fim_erro_holds", db_estado, 4'hC);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("erro_restart", db_estado, 4'h1);
    check("erro_restart_zeracr", zeraCR, 1'b1);

    // Timeout, then play and timeout together
    wait_state(4'h5, "espera_to");
    timeout = 1'b1;
    step();
    timeout = 1'b0;
    check("fim_timeout", db_estado, 4'hD);
    check("fim_timeout_outs", outs, OPr | OEr | OTo);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("timeout_restart", db_estado, 4'h1);
    wait_state(4'h5, "espera_both");
    jogada_feita = 1'b1;
    timeout = 1'b1;
    step();
    jogada_feita = 1'b0;
    timeout = 1'b0;
    check("play_beats_timeout", db_estado, 4'h6);

    // Full 16-round game
    reset = 1'b0;
    step();
    reset = 1'b1;
    cr_base = cr_count;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int r = 0; r < 16; r++) run_round(r + 1, r == 15);
    check("win_outs", outs, OPr | OAc);
    check("contacr_pulses", cr_count - cr_base, 15);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    check("win_restart", db_estado, 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
